spi_slave_endpoint: RTL

//   SPI slave endpoint. Consumes the sclk/ss/mosi produced by the APB SPI master and returns miso.

---
 rtl/spi_slave_endpoint.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/spi_slave_endpoint.sv
// SPI slave endpoint, oversampled in the PCLK domain (no sclk-clocked flops).
// Bytes move to/from local logic through a 1-deep TX holding register and an RX register.
module spi_slave_endpoint #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsbfe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  abort
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_hist, ss_hist;
    logic                   cpol_l, cpha_l, lsbfe_l;
    logic [DATA_WIDTH-1:0]  hold;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [CW-1:0]          count;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic sample_edge, shift_edge;
    logic [DATA_WIDTH-1:0] load_word, rx_word, rx_final;

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) r[i] = v[DATA_WIDTH-1-i];
        return r;
    endfunction

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_hist <= 1'b0;
            ss_hist   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            ss_hist   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist;
    assign sclk_fall = ~sclk_s & sclk_hist;
    assign ss_fall   = ~ss_s & ss_hist;
    assign ss_rise   = ss_s & ~ss_hist;

    assign sample_edge = (cpol_l == cpha_l) ? sclk_rise : sclk_fall;
    assign shift_edge  = (cpol_l == cpha_l) ? sclk_fall : sclk_rise;

    // Both shifters always run MSB-first; LSB-first frames are bit-reversed at load/unload.
    assign load_word = tx_ready ? '1 : (lsbfe_l ? bit_rev(hold) : hold);
    assign rx_word   = {rx_shift, mosi_s};
    assign rx_final  = lsbfe_l ? bit_rev(rx_word) : rx_word;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= ST_IDLE;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            hold     <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            count    <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            lsbfe_l  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
        end else begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        cpol_l  <= cpol;
                        cpha_l  <= cpha;
                        lsbfe_l <= lsbfe;
                        miso_oe <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // cpha=0 presents the first bit now, so the shifter starts one bit ahead.
                    tx_shift <= cpha_l ? load_word : (load_word << 1);
                    if (!cpha_l) miso <= load_word[DATA_WIDTH-1];
                    underrun <= tx_ready;
                    tx_ready <= 1'b1;
                    count    <= '0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (sample_edge) begin
                        rx_shift <= rx_word[DATA_WIDTH-2:0];
                        if (count == LAST_BIT) begin
                            count    <= '0;
                            rx_data  <= rx_final;
                            rx_valid <= 1'b1;
                            overrun  <= rx_valid && !rx_ready;
                            tx_shift <= cpha_l ? load_word : (load_word << 1);
                            if (!cpha_l) miso <= load_word[DATA_WIDTH-1];
                            underrun <= tx_ready;
                            tx_ready <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else if (shift_edge && (cpha_l || count != '0)) begin
                        // With cpha=0 the shift edge at count 0 is the trailing edge of the last bit.
                        miso     <= tx_shift[DATA_WIDTH-1];
                        tx_shift <= tx_shift << 1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (ss_rise) begin
                state   <= ST_IDLE;
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                busy    <= 1'b0;
                count   <= '0;
                abort   <= (state == ST_SHIFT) && (count != '0);
            end

            if (tx_valid && tx_ready) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule
